// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl
// Handshaked, byte-addressed, Big-Endian data memory for the load/store stage.
// It supports byte, half, word and double accesses. Loads are zero- or
// sign-extended. Misaligned and out-of-range accesses are flagged. The
// latency from request acceptance to response is configurable. Only one
// request is outstanding at a time.
//
// Ports:
//   clk, reset           clock (rising edge) and asynchronous active-high reset
//   req_valid/req_ready  request handshake
//   req_write            1 = store, 0 = load
//   req_size             0 byte, 1 half, 2 word, 3 double
//   req_unsigned         loads zero-extend when set, sign-extend otherwise
//   req_addr             byte address
//   req_wdata            right-justified store data
//   resp_valid/ready     response handshake
//   resp_rdata           extended load result (0 for stores and errors)
//   resp_error           misaligned or out-of-range access
module data_memory_ctrl #(
  parameter int DEPTH_BYTES = 1024,
  parameter int XLEN        = 64,
  parameter int LATENCY     = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_error
);

  localparam int AW = $clog2(DEPTH_BYTES);
  // The counter only ever holds LATENCY-2 at most.
  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   count, count_next;

  logic            wr_q, uns_q;
  logic [1:0]      size_q;
  logic [XLEN-1:0] addr_q, wdata_q;

  logic [7:0]      mem [DEPTH_BYTES];

  logic [XLEN-1:0] rdata_q;
  logic            error_q;

  // Fields of the access being performed on this edge
  logic            acc_write, acc_uns, acc_error, enter_resp;
  logic [1:0]      acc_size;
  logic [XLEN-1:0] acc_addr, acc_wdata;
  logic [AW-1:0]   acc_base;
  logic [3:0]      nbytes;
  logic [6:0]      shamt;
  logic [XLEN-1:0] raw_left, raw, wd_left, ext;
  logic            misaligned;

  // State register and latency counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // Next-state logic.
  // With LATENCY = 1 the access happens on the acceptance edge itself.
  // Otherwise WAIT counts down from LATENCY-2 and exits on the edge after
  // the counter reaches zero.
  always_comb begin
    state_next = state;
    count_next = count;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (LATENCY == 1) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            count_next = CW'(LATENCY - 2);
          end
        end
      end
      WAIT: begin
        if (count == '0) state_next = RESP;
        else             count_next = count - CW'(1);
      end
      RESP: begin
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request fields are captured at acceptance, so the requester may change them afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state == IDLE && req_valid) begin
      wr_q    <= req_write;
      uns_q   <= req_unsigned;
      size_q  <= req_size;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // The access uses the live request when it happens on the acceptance edge
  // (LATENCY = 1). Otherwise it uses the latched copy.
  // Data is handled left-justified so that the byte at the lowest address
  // always sits in the top byte lane. A shift then right-justifies it.
  always_comb begin
    acc_write  = (state == IDLE) ? req_write    : wr_q;
    acc_uns    = (state == IDLE) ? req_unsigned : uns_q;
    acc_size   = (state == IDLE) ? req_size     : size_q;
    acc_addr   = (state == IDLE) ? req_addr     : addr_q;
    acc_wdata  = (state == IDLE) ? req_wdata    : wdata_q;
    acc_base   = acc_addr[AW-1:0];
    nbytes     = 4'd1 << acc_size;
    shamt      = {4'd8 - nbytes, 3'b000};
    enter_resp = (state != RESP) && (state_next == RESP);

    case (acc_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = acc_addr[0];
      2'd2:    misaligned = |acc_addr[1:0];
      default: misaligned = |acc_addr[2:0];
    endcase
    acc_error = misaligned || (|acc_addr[XLEN-1:AW]);

    raw_left = '0;
    for (int i = 0; i < 8; i++) begin
      raw_left[XLEN-1-8*i -: 8] = mem[acc_base + AW'(i)];
    end
    raw     = raw_left >> shamt;
    wd_left = acc_wdata << shamt;

    case (acc_size)
      2'd0:    ext = {{(XLEN-8){~acc_uns & raw[7]}},   raw[7:0]};
      2'd1:    ext = {{(XLEN-16){~acc_uns & raw[15]}}, raw[15:0]};
      2'd2:    ext = {{(XLEN-32){~acc_uns & raw[31]}}, raw[31:0]};
      default: ext = raw;
    endcase
  end

  // Byte storage.
  // The whole array is cleared by reset. A store commits only on the edge
  // entering RESP, so a store interrupted by reset is never committed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < DEPTH_BYTES; j++) mem[j] <= 8'h00;
    end else if (enter_resp && acc_write && !acc_error) begin
      for (int i = 0; i < 8; i++) begin
        if (4'(i) < nbytes) mem[acc_base + AW'(i)] <= wd_left[XLEN-1-8*i -: 8];
      end
    end
  end

  // Response registers.
  // They are loaded when RESP is entered and cleared on the handshake, so
  // they read zero whenever no response is presented.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
      error_q <= 1'b0;
    end else if (enter_resp) begin
      error_q <= acc_error;
      rdata_q <= (acc_write || acc_error) ? '0 : ext;
    end else if (state == RESP && resp_ready) begin
      rdata_q <= '0;
      error_q <= 1'b0;
    end
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_rdata = rdata_q;
  assign resp_error = error_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb_data_memory_ctrl
// Drives two controllers in lockstep: one with LATENCY 1 and one with
// LATENCY 4. Both share the request fields. Each has its own req_valid and
// resp_ready.
// A behavioural model computes each access from a plain byte array at
// acceptance time and predicts when the response appears.
// A compare process checks every output of both instances on each falling
// edge. Directed transactions pin the model with literal values.
module tb_data_memory_ctrl;

  localparam int DEPTH = 1024;

  logic        clk;
  logic        reset;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        req_valid  [2];
  logic        resp_ready [2];
  logic        req_ready  [2];
  logic        resp_valid [2];
  logic [63:0] resp_rdata [2];
  logic        resp_error [2];

  int total = 0;
  int bad   = 0;
  bit armed = 0;

  logic [63:0] cap_rd [2];
  logic        cap_er [2];

  data_memory_ctrl #(.DEPTH_BYTES(DEPTH), .XLEN(64), .LATENCY(1)) dut_l1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_error(resp_error[0])
  );

  data_memory_ctrl #(.DEPTH_BYTES(DEPTH), .XLEN(64), .LATENCY(4)) dut_l4 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_error(resp_error[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  // Reference model: byte arrays plus a phase for each instance.
  typedef enum {M_IDLE, M_BUSY, M_RESP} phase_t;
  phase_t          ph [2];
  longint unsigned cyc;
  longint unsigned due [2];
  logic [63:0]     m_rdata [2];
  logic            m_err [2];
  logic [7:0]      mem_m [2][DEPTH];

  function automatic bit model_err(input logic [63:0] a, input logic [1:0] sz);
    longint unsigned nb;
    nb = longint'(1) << sz;
    return ((a % nb) != 0) || (a >= 64'(DEPTH));
  endfunction

  function automatic logic [63:0] model_load(input int k, input logic [63:0] a,
                                             input logic [1:0] sz, input logic u);
    int nb;
    logic [63:0] v;
    nb = 1 << sz;
    v = 64'd0;
    for (int i = 0; i < nb; i++) v = (v << 8) | 64'(mem_m[k][int'(a) + i]);
    if (!u && nb < 8 && v[8*nb-1]) v = v | ~((64'd1 << (8*nb)) - 64'd1);
    return v;
  endfunction

  // Model update.
  // The access result is computed at acceptance. Only one access is ever
  // outstanding, and reset clears memory anyway, so committing early is
  // equivalent. The response becomes visible LATENCY-1 edges after acceptance.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc <= 0;
      for (int k = 0; k < 2; k++) begin
        ph[k]      <= M_IDLE;
        due[k]     <= 0;
        m_rdata[k] <= 64'd0;
        m_err[k]   <= 1'b0;
        for (int j = 0; j < DEPTH; j++) mem_m[k][j] <= 8'h00;
      end
    end else begin
      cyc <= cyc + 1;
      for (int k = 0; k < 2; k++) begin
        case (ph[k])
          M_IDLE: begin
            if (req_valid[k]) begin
              due[k] <= cyc + longint'(lat_of(k)) - 1;
              ph[k]  <= (lat_of(k) == 1) ? M_RESP : M_BUSY;
              if (model_err(req_addr, req_size)) begin
                m_err[k]   <= 1'b1;
                m_rdata[k] <= 64'd0;
              end else if (req_write) begin
                m_err[k]   <= 1'b0;
                m_rdata[k] <= 64'd0;
                for (int i = 0; i < 8; i++) begin
                  if (i < (1 << req_size))
                    mem_m[k][int'(req_addr) + i] <= 8'(req_wdata >> (8 * ((1 << req_size) - 1 - i)));
                end
              end else begin
                m_err[k]   <= 1'b0;
                m_rdata[k] <= model_load(k, req_addr, req_size, req_unsigned);
              end
            end
          end
          M_BUSY: if (cyc == due[k]) ph[k] <= M_RESP;
          default: if (resp_ready[k]) ph[k] <= M_IDLE;
        endcase
      end
    end
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Compare process: every output of both instances on every falling edge.
  always @(negedge clk) begin
    if (armed) begin
      for (int k = 0; k < 2; k++) begin
        check_output($sformatf("req_ready[%0d]", k), 64'(req_ready[k]), 64'(ph[k] == M_IDLE));
        check_output($sformatf("resp_valid[%0d]", k), 64'(resp_valid[k]), 64'(ph[k] == M_RESP));
        check_output($sformatf("resp_rdata[%0d]", k), resp_rdata[k],
                     (ph[k] == M_RESP) ? m_rdata[k] : 64'd0);
        check_output($sformatf("resp_error[%0d]", k), 64'(resp_error[k]),
                     64'((ph[k] == M_RESP) && m_err[k]));
      end
    end
  end

  // Issue one request to both instances. Optionally keep req_valid high
  // while the access is in flight. Hold resp_ready low for 'hold' cycles
  // once the response is up, then capture the response and complete the
  // handshake.
  task automatic apply_stimulus(input logic w, input logic [1:0] sz, input logic u,
                                input logic [63:0] a, input logic [63:0] wd,
                                input int hold, input logic pending);
    int st [2];
    int waited [2];
    int held [2];
    for (int k = 0; k < 2; k++) begin
      st[k] = 0;
      waited[k] = 0;
      held[k] = 0;
    end
    @(negedge clk);
    #1;
    req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
    req_valid[0] = 1'b1; req_valid[1] = 1'b1;
    @(posedge clk);
    #1;
    req_write    = 1'($urandom);
    req_size     = 2'($urandom);
    req_unsigned = 1'($urandom);
    req_addr     = {$urandom, $urandom};
    req_wdata    = {$urandom, $urandom};
    if (!pending) begin
      req_valid[0] = 1'b0;
      req_valid[1] = 1'b0;
    end
    for (int c = 0; c < 60 && !(st[0] == 3 && st[1] == 3); c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (st[k] == 2) begin
          resp_ready[k] = 1'b0;
          req_valid[k]  = 1'b0;
          st[k] = 3;
        end else if (st[k] != 3) begin
          if (st[k] == 0) begin
            if (!resp_valid[k]) begin
              waited[k]++;
            end else begin
              check_output($sformatf("latency[%0d]", k), 64'(waited[k]), 64'(lat_of(k) - 1));
              st[k] = 1;
            end
          end
          if (st[k] == 1) begin
            if (held[k] >= hold) begin
              cap_rd[k] = resp_rdata[k];
              cap_er[k] = resp_error[k];
              resp_ready[k] = 1'b1;
              st[k] = 2;
            end else begin
              held[k]++;
            end
          end
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      if (st[k] != 3) begin
        check_output($sformatf("handshake_timeout[%0d]", k), 64'(st[k]), 64'd3);
        resp_ready[k] = 1'b0;
        req_valid[k]  = 1'b0;
      end
    end
  endtask

  task automatic check_pair(input string name, input logic [63:0] exp_rd, input logic exp_er);
    for (int k = 0; k < 2; k++) begin
      check_output($sformatf("%s rdata[%0d]", name, k), cap_rd[k], exp_rd);
      check_output($sformatf("%s error[%0d]", name, k), 64'(cap_er[k]), 64'(exp_er));
    end
  endtask

  task automatic check_reset_values(input string name);
    for (int k = 0; k < 2; k++) begin
      check_output($sformatf("%s req_ready[%0d]", name, k), 64'(req_ready[k]), 64'd1);
      check_output($sformatf("%s resp_valid[%0d]", name, k), 64'(resp_valid[k]), 64'd0);
      check_output($sformatf("%s resp_rdata[%0d]", name, k), resp_rdata[k], 64'd0);
      check_output($sformatf("%s resp_error[%0d]", name, k), 64'(resp_error[k]), 64'd0);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got hang expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0]  sz;
    logic [63:0] a;
    int          nb;
    int          sel;

    reset = 1'b0;
    req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 64'd0; req_wdata = 64'd0;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0;
      resp_ready[k] = 1'b0;
      cap_rd[k] = 64'd0;
      cap_er[k] = 1'b0;
    end
    #2 reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("initial reset");
    #1 reset = 1'b0;
    armed = 1'b1;
    $display("[TB] directed accesses");

    apply_stimulus(1'b1, 2'd3, 1'b0, 64'h10, 64'h0123456789ABCDEF, 0, 1'b0);
    check_pair("store D 0x10", 64'd0, 1'b0);
    apply_stimulus(1'b0, 2'd3, 1'b0, 64'h10, 64'd0, 0, 1'b0);
    check_pair("load D 0x10", 64'h0123456789ABCDEF, 1'b0);
    apply_stimulus(1'b0, 2'd0, 1'b0, 64'h14, 64'd0, 0, 1'b0);
    check_pair("load sB 0x14", 64'hFFFFFFFFFFFFFF89, 1'b0);
    apply_stimulus(1'b0, 2'd0, 1'b1, 64'h14, 64'd0, 0, 1'b0);
    check_pair("load uB 0x14", 64'h89, 1'b0);
    apply_stimulus(1'b0, 2'd1, 1'b0, 64'h12, 64'd0, 0, 1'b0);
    check_pair("load sH 0x12", 64'h4567, 1'b0);
    apply_stimulus(1'b0, 2'd2, 1'b1, 64'h14, 64'd0, 0, 1'b0);
    check_pair("load uW 0x14", 64'h89ABCDEF, 1'b0);
    apply_stimulus(1'b0, 2'd2, 1'b0, 64'h14, 64'd0, 0, 1'b0);
    check_pair("load sW 0x14", 64'hFFFFFFFF89ABCDEF, 1'b0);
    apply_stimulus(1'b1, 2'd1, 1'b0, 64'h16, 64'h111122223333BEEF, 0, 1'b0);
    check_pair("store H 0x16", 64'd0, 1'b0);
    apply_stimulus(1'b0, 2'd3, 1'b1, 64'h10, 64'd0, 0, 1'b0);
    check_pair("load D after half", 64'h0123456789ABBEEF, 1'b0);
    apply_stimulus(1'b1, 2'd2, 1'b0, 64'h22, 64'hDEADBEEFCAFEF00D, 0, 1'b0);
    check_pair("store W 0x22 misaligned", 64'd0, 1'b1);
    apply_stimulus(1'b0, 2'd2, 1'b1, 64'h20, 64'd0, 0, 1'b0);
    check_pair("load W 0x20 untouched", 64'd0, 1'b0);
    apply_stimulus(1'b0, 2'd3, 1'b0, 64'h400, 64'd0, 0, 1'b0);
    check_pair("load D 0x400 range", 64'd0, 1'b1);

    $display("[TB] backpressure with pending request");
    apply_stimulus(1'b0, 2'd3, 1'b0, 64'h10, 64'd0, 5, 1'b1);
    check_pair("load D held", 64'h0123456789ABBEEF, 1'b0);

    $display("[TB] reset during an access");
    @(negedge clk);
    #1;
    req_write = 1'b1; req_size = 2'd3; req_unsigned = 1'b0;
    req_addr = 64'h08; req_wdata = 64'hA5A5A5A5A5A5A5A5;
    req_valid[0] = 1'b1; req_valid[1] = 1'b1;
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0; req_valid[1] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check_reset_values("mid-access reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b0;
    apply_stimulus(1'b0, 2'd3, 1'b0, 64'h08, 64'd0, 0, 1'b0);
    check_pair("load D 0x08 after reset", 64'd0, 1'b0);

    $display("[TB] random accesses");
    for (int n = 0; n < 150; n++) begin
      sz  = 2'($urandom_range(0, 3));
      nb  = 1 << sz;
      sel = $urandom_range(0, 19);
      if (sel == 0)      a = 64'($urandom_range(0, 63));
      else if (sel == 1) a = 64'(DEPTH) + 64'($urandom_range(0, 4096));
      else if (sel == 2) a = 64'(DEPTH - nb);
      else if (sel == 3) a = {$urandom, $urandom};
      else               a = 64'($urandom_range(0, 63)) & ~64'(nb - 1);
      apply_stimulus(1'($urandom), sz, 1'($urandom), a, {$urandom, $urandom},
                     $urandom_range(0, 3), 1'($urandom));
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
